// File: rtl/vga_timing_if.sv
// ---------------------------------------------------------------------------
// vga_timing_if
// Raster timing stream from vga_timing_gen to the pixel pipelines and the
// VGA connector.
//   DrawX / DrawY  : current column / row counters
//   blank          : 1 = visible pixel, 0 = blanking (same cycle as DrawX/Y)
//   hs / vs        : sync outputs, already delayed to match renderer latency
//   line_start     : 1-cycle pulse at DrawX == 0
//   frame_start    : 1-cycle pulse at DrawX == 0 and DrawY == 0
//   frame_count    : completed-frame counter, wraps modulo 2^16
// master = timing generator, slave = consumers.
// ---------------------------------------------------------------------------
interface vga_timing_if;
    logic [9:0]  DrawX;
    logic [9:0]  DrawY;
    logic        blank;
    logic        hs;
    logic        vs;
    logic        line_start;
    logic        frame_start;
    logic [15:0] frame_count;

    modport master (
        output DrawX, DrawY, blank, hs, vs, line_start, frame_start, frame_count
    );

    modport slave (
        input  DrawX, DrawY, blank, hs, vs, line_start, frame_start, frame_count
    );
endinterface

// File: rtl/vga_timing_gen.sv
// ---------------------------------------------------------------------------
// vga_timing_gen
// Free-running raster timing generator (640x480@60 by default).
//   vga_clk : pixel clock, all logic on posedge
//   reset   : synchronous, active-high; clears counters and the sync delay line
//   vga     : vga_timing_if.master - DrawX/DrawY/blank/strobes/frame_count
//             plus hs/vs delayed PIPE_DLY cycles so sync edges line up with
//             the renderers' registered pixel colours.
// ---------------------------------------------------------------------------
module vga_timing_gen #(
    parameter int unsigned H_ACTIVE = 640,
    parameter int unsigned H_FP     = 16,
    parameter int unsigned H_SYNC   = 96,
    parameter int unsigned H_BP     = 48,
    parameter int unsigned V_ACTIVE = 480,
    parameter int unsigned V_FP     = 10,
    parameter int unsigned V_SYNC   = 2,
    parameter int unsigned V_BP     = 33,
    parameter int unsigned PIPE_DLY = 1,
    parameter bit          SYNC_POL = 1'b0
) (
    input  logic         vga_clk,
    input  logic         reset,
    vga_timing_if.master vga
);

    localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam logic [9:0] H_LAST     = 10'(H_TOTAL - 1);
    localparam logic [9:0] V_LAST     = 10'(V_TOTAL - 1);
    localparam logic [9:0] H_VIS_END  = 10'(H_ACTIVE);
    localparam logic [9:0] V_VIS_END  = 10'(V_ACTIVE);
    localparam logic [9:0] HS_START   = 10'(H_ACTIVE + H_FP);
    localparam logic [9:0] HS_END     = 10'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [9:0] VS_START   = 10'(V_ACTIVE + V_FP);
    localparam logic [9:0] VS_END     = 10'(V_ACTIVE + V_FP + V_SYNC);

    logic [9:0]  draw_x_q, draw_x_d;
    logic [9:0]  draw_y_q, draw_y_d;
    logic [15:0] frame_count_q, frame_count_d;

    logic end_of_line;
    logic end_of_frame;
    logic hs_raw;
    logic vs_raw;
    logic hs_lvl;
    logic vs_lvl;

    // ---------------------------------------------------------------
    // Raster counters
    // ---------------------------------------------------------------
    always_comb begin
        end_of_line   = (draw_x_q == H_LAST);
        end_of_frame  = end_of_line && (draw_y_q == V_LAST);
        draw_x_d      = draw_x_q + 10'd1;
        draw_y_d      = draw_y_q;
        frame_count_d = frame_count_q;
        if (end_of_line) begin
            draw_x_d = '0;
            if (draw_y_q == V_LAST) begin
                draw_y_d = '0;
            end else begin
                draw_y_d = draw_y_q + 10'd1;
            end
        end
        // Counts completed frames, so it bumps on the last pixel of a frame
        // and is already new when frame_start pulses at (0,0).
        if (end_of_frame) begin
            frame_count_d = frame_count_q + 16'd1;
        end
    end

    always_ff @(posedge vga_clk) begin
        if (reset) begin
            draw_x_q      <= '0;
            draw_y_q      <= '0;
            frame_count_q <= '0;
        end else begin
            draw_x_q      <= draw_x_d;
            draw_y_q      <= draw_y_d;
            frame_count_q <= frame_count_d;
        end
    end

    // ---------------------------------------------------------------
    // Undelayed sync decode, expressed as output levels
    // ---------------------------------------------------------------
    assign hs_raw = (draw_x_q >= HS_START) && (draw_x_q < HS_END);
    assign vs_raw = (draw_y_q >= VS_START) && (draw_y_q < VS_END);
    assign hs_lvl = hs_raw ? SYNC_POL : ~SYNC_POL;
    assign vs_lvl = vs_raw ? SYNC_POL : ~SYNC_POL;

    // ---------------------------------------------------------------
    // Sync delay line. Stages hold output levels rather than "asserted"
    // flags so reset can preload the idle level directly; that keeps a
    // mid-sync reset from leaking stale sync pulses out of the chain.
    // ---------------------------------------------------------------
    generate
        if (PIPE_DLY == 0) begin : g_no_dly
            assign vga.hs = hs_lvl;
            assign vga.vs = vs_lvl;
        end else begin : g_dly
            logic [PIPE_DLY-1:0] hs_pipe_q, hs_pipe_d;
            logic [PIPE_DLY-1:0] vs_pipe_q, vs_pipe_d;

            always_comb begin
                hs_pipe_d    = hs_pipe_q;
                vs_pipe_d    = vs_pipe_q;
                hs_pipe_d[0] = hs_lvl;
                vs_pipe_d[0] = vs_lvl;
                for (int i = 1; i < int'(PIPE_DLY); i++) begin
                    hs_pipe_d[i] = hs_pipe_q[i-1];
                    vs_pipe_d[i] = vs_pipe_q[i-1];
                end
            end

            always_ff @(posedge vga_clk) begin
                if (reset) begin
                    hs_pipe_q <= {PIPE_DLY{~SYNC_POL}};
                    vs_pipe_q <= {PIPE_DLY{~SYNC_POL}};
                end else begin
                    hs_pipe_q <= hs_pipe_d;
                    vs_pipe_q <= vs_pipe_d;
                end
            end

            assign vga.hs = hs_pipe_q[PIPE_DLY-1];
            assign vga.vs = vs_pipe_q[PIPE_DLY-1];
        end
    endgenerate

    // ---------------------------------------------------------------
    // Stream outputs: counters go out directly; decodes are zero-latency.
    // Strobes are gated by reset so consumers never see a start pulse
    // while the raster is held.
    // ---------------------------------------------------------------
    assign vga.DrawX       = draw_x_q;
    assign vga.DrawY       = draw_y_q;
    assign vga.frame_count = frame_count_q;
    assign vga.blank       = (draw_x_q < H_VIS_END) && (draw_y_q < V_VIS_END);
    assign vga.line_start  = ~reset && (draw_x_q == '0);
    assign vga.frame_start = ~reset && (draw_x_q == '0) && (draw_y_q == '0);

endmodule

// File: tb/tb_vga_timing_gen.sv
module tb_vga_timing_gen;

    typedef struct packed {
        int x;
        int y;
        int bl;
        int hs;
        int vs;
        int ls;
        int fs;
        int fc;
    } exp_t;

    logic clk;
    logic reset;
    int   cyc;
    int   fc_off;
    bit   started;
    int   n_chk;
    int   n_err;

    // dd: default geometry; s0/s1/s3: reduced 30x15 geometry with PIPE_DLY 0/1/3
    vga_timing_if if_dd();
    vga_timing_if if_s0();
    vga_timing_if if_s1();
    vga_timing_if if_s3();

    vga_timing_gen #(.PIPE_DLY(1), .SYNC_POL(1'b0)) u_dd (
        .vga_clk(clk), .reset(reset), .vga(if_dd)
    );
    vga_timing_gen #(.H_ACTIVE(16), .H_FP(4), .H_SYNC(6), .H_BP(4),
                     .V_ACTIVE(8), .V_FP(2), .V_SYNC(2), .V_BP(3),
                     .PIPE_DLY(0), .SYNC_POL(1'b0)) u_s0 (
        .vga_clk(clk), .reset(reset), .vga(if_s0)
    );
    vga_timing_gen #(.H_ACTIVE(16), .H_FP(4), .H_SYNC(6), .H_BP(4),
                     .V_ACTIVE(8), .V_FP(2), .V_SYNC(2), .V_BP(3),
                     .PIPE_DLY(1), .SYNC_POL(1'b0)) u_s1 (
        .vga_clk(clk), .reset(reset), .vga(if_s1)
    );
    vga_timing_gen #(.H_ACTIVE(16), .H_FP(4), .H_SYNC(6), .H_BP(4),
                     .V_ACTIVE(8), .V_FP(2), .V_SYNC(2), .V_BP(3),
                     .PIPE_DLY(3), .SYNC_POL(1'b1)) u_s3 (
        .vga_clk(clk), .reset(reset), .vga(if_s3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: everything follows from cyc = clock edges since the last
    // reset edge. Position in the frame is cyc mod frame length; a sync
    // output shows the raw sync of position cyc-dly, or idle if that
    // position lies before the reset.
    function automatic exp_t model(int ha, int hf, int hw, int hb,
                                   int va, int vf, int vw, int vb,
                                   int dly, bit pol, int c, bit rst, int off);
        exp_t e;
        int ht, vt, fl, p, q, qx, qy;
        bit h_on, v_on;
        ht = ha + hf + hw + hb;
        vt = va + vf + vw + vb;
        fl = ht * vt;
        p  = c % fl;
        e.x  = p % ht;
        e.y  = p / ht;
        e.bl = (e.x < ha && e.y < va) ? 1 : 0;
        h_on = 1'b0;
        v_on = 1'b0;
        if (c >= dly) begin
            q  = (c - dly) % fl;
            qx = q % ht;
            qy = q / ht;
            h_on = (qx >= ha + hf) && (qx < ha + hf + hw);
            v_on = (qy >= va + vf) && (qy < va + vf + vw);
        end
        e.hs = h_on ? int'(pol) : int'(!pol);
        e.vs = v_on ? int'(pol) : int'(!pol);
        e.ls = (!rst && e.x == 0) ? 1 : 0;
        e.fs = (e.ls == 1 && e.y == 0) ? 1 : 0;
        e.fc = (c / fl + off) % 65536;
        return e;
    endfunction

    task automatic chk(string name, int act, int req);
        n_chk++;
        if (act != req) begin
            n_err++;
            $display("FAIL %s actual=%0d required=%0d (cyc=%0d)", name, act, req, cyc);
        end
    endtask

    task automatic cmp_dut(string tag, exp_t e, int x, int y, int bl, int h,
                           int v, int ls, int fs, int fc);
        chk({tag, ".DrawX"}, x, e.x);
        chk({tag, ".DrawY"}, y, e.y);
        chk({tag, ".blank"}, bl, e.bl);
        chk({tag, ".hs"}, h, e.hs);
        chk({tag, ".vs"}, v, e.vs);
        chk({tag, ".line_start"}, ls, e.ls);
        chk({tag, ".frame_start"}, fs, e.fs);
        chk({tag, ".frame_count"}, fc, e.fc);
    endtask

    always @(negedge clk) begin
        if (started) begin
            cmp_dut("dd", model(640, 16, 96, 48, 480, 10, 2, 33, 1, 1'b0, cyc, reset, 0),
                    if_dd.DrawX, if_dd.DrawY, if_dd.blank, if_dd.hs, if_dd.vs,
                    if_dd.line_start, if_dd.frame_start, if_dd.frame_count);
            cmp_dut("s0", model(16, 4, 6, 4, 8, 2, 2, 3, 0, 1'b0, cyc, reset, 0),
                    if_s0.DrawX, if_s0.DrawY, if_s0.blank, if_s0.hs, if_s0.vs,
                    if_s0.line_start, if_s0.frame_start, if_s0.frame_count);
            cmp_dut("s1", model(16, 4, 6, 4, 8, 2, 2, 3, 1, 1'b0, cyc, reset, fc_off),
                    if_s1.DrawX, if_s1.DrawY, if_s1.blank, if_s1.hs, if_s1.vs,
                    if_s1.line_start, if_s1.frame_start, if_s1.frame_count);
            cmp_dut("s3", model(16, 4, 6, 4, 8, 2, 2, 3, 3, 1'b1, cyc, reset, 0),
                    if_s3.DrawX, if_s3.DrawY, if_s3.blank, if_s3.hs, if_s3.vs,
                    if_s3.line_start, if_s3.frame_start, if_s3.frame_count);
        end
    end

    // One clock edge; inputs change 1 time unit after it.
    task automatic step();
        @(posedge clk);
        if (reset) begin
            cyc    = 0;
            fc_off = 0;
        end else begin
            cyc++;
        end
        #1;
    endtask

    // Advance to raster position t, then settle just after the falling edge.
    task automatic run_to(int t);
        int guard;
        guard = 0;
        while (cyc != t && guard < 500000) begin
            step();
            guard++;
        end
        if (cyc != t) chk("run_to_budget", cyc, t);
        @(negedge clk);
        #1;
    endtask

    initial begin
        reset   = 1'b1;
        cyc     = 0;
        fc_off  = 0;
        started = 1'b0;
        n_chk   = 0;
        n_err   = 0;

        // Power-up reset for 3 edges
        step();
        started = 1'b1;
        step();
        @(negedge clk);
        #1;
        chk("held.DrawX", int'(if_dd.DrawX), 0);
        chk("held.line_start", int'(if_dd.line_start), 0);
        chk("held.frame_start", int'(if_dd.frame_start), 0);
        chk("held.hs", int'(if_dd.hs), 1);
        step();
        reset = 1'b0;

        // First cycle after reset
        run_to(0);
        chk("c0.DrawX", int'(if_dd.DrawX), 0);
        chk("c0.DrawY", int'(if_dd.DrawY), 0);
        chk("c0.blank", int'(if_dd.blank), 1);
        chk("c0.frame_start", int'(if_dd.frame_start), 1);
        chk("c0.line_start", int'(if_dd.line_start), 1);
        chk("c0.hs", int'(if_dd.hs), 1);
        chk("c0.vs", int'(if_dd.vs), 1);
        chk("c0.frame_count", int'(if_dd.frame_count), 0);

        // Small geometry: hsync [20,26), vsync lines [10,12), 450 cycles/frame
        run_to(19);  chk("s0.hs@19", int'(if_s0.hs), 1);
        run_to(20);  chk("s0.hs@20", int'(if_s0.hs), 0);
        run_to(22);  chk("s3.hs@22", int'(if_s3.hs), 0);
        run_to(23);  chk("s3.hs@23", int'(if_s3.hs), 1);
        run_to(28);  chk("s3.hs@28", int'(if_s3.hs), 1);
        run_to(29);  chk("s3.hs@29", int'(if_s3.hs), 0);
        run_to(300); chk("s1.vs@300", int'(if_s1.vs), 1);
        run_to(301); chk("s1.vs@301", int'(if_s1.vs), 0);
        run_to(360); chk("s1.vs@360", int'(if_s1.vs), 0);
        run_to(361); chk("s1.vs@361", int'(if_s1.vs), 1);
        run_to(449);
        chk("s1.fc@449", int'(if_s1.frame_count), 0);
        chk("s1.DrawY@449", int'(if_s1.DrawY), 14);
        run_to(450);
        chk("s1.fc@450", int'(if_s1.frame_count), 1);
        chk("s1.fs@450", int'(if_s1.frame_start), 1);
        chk("s1.DrawX@450", int'(if_s1.DrawX), 0);

        // Default geometry line timing
        run_to(639); chk("dd.blank@639", int'(if_dd.blank), 1);
        run_to(640);
        chk("dd.blank@640", int'(if_dd.blank), 0);
        chk("dd.DrawX@640", int'(if_dd.DrawX), 640);
        run_to(656); chk("dd.hs@656", int'(if_dd.hs), 1);
        run_to(657); chk("dd.hs@657", int'(if_dd.hs), 0);
        run_to(752); chk("dd.hs@752", int'(if_dd.hs), 0);
        run_to(753); chk("dd.hs@753", int'(if_dd.hs), 1);
        run_to(799);
        chk("dd.DrawX@799", int'(if_dd.DrawX), 799);
        chk("dd.ls@799", int'(if_dd.line_start), 0);
        run_to(800);
        chk("dd.DrawX@800", int'(if_dd.DrawX), 0);
        chk("dd.DrawY@800", int'(if_dd.DrawY), 1);
        chk("dd.ls@800", int'(if_dd.line_start), 1);
        chk("dd.fs@800", int'(if_dd.frame_start), 0);
        run_to(2400); chk("dd.DrawY@2400", int'(if_dd.DrawY), 3);

        // Reset in the middle of both syncs (small geometry x=23, y=11)
        reset = 1'b1;
        step();
        step();
        reset = 1'b0;
        run_to(353);
        chk("mid.s1.DrawX", int'(if_s1.DrawX), 23);
        chk("mid.s1.DrawY", int'(if_s1.DrawY), 11);
        chk("mid.s1.hs", int'(if_s1.hs), 0);
        chk("mid.s1.vs", int'(if_s1.vs), 0);
        chk("mid.s3.hs", int'(if_s3.hs), 1);
        reset = 1'b1;
        step();
        reset = 1'b0;
        @(negedge clk);
        #1;
        chk("post.s1.DrawX", int'(if_s1.DrawX), 0);
        chk("post.s1.DrawY", int'(if_s1.DrawY), 0);
        chk("post.s1.hs", int'(if_s1.hs), 1);
        chk("post.s1.vs", int'(if_s1.vs), 1);
        chk("post.s3.hs", int'(if_s3.hs), 0);
        chk("post.s3.vs", int'(if_s3.vs), 0);
        chk("post.s1.fs", int'(if_s1.frame_start), 1);

        // frame_count wrap: preload 65535 late in the second frame
        run_to(897);
        force u_s1.frame_count_q = 16'hFFFF;
        fc_off = 16'hFFFE;
        #1;
        release u_s1.frame_count_q;
        run_to(899);
        chk("wrap.fc@899", int'(if_s1.frame_count), 65535);
        run_to(900);
        chk("wrap.fc@900", int'(if_s1.frame_count), 0);
        chk("wrap.fs@900", int'(if_s1.frame_start), 1);
        chk("wrap.DrawX@900", int'(if_s1.DrawX), 0);

        // Random run lengths with random-length resets at arbitrary points
        for (int r = 0; r < 12; r++) begin
            repeat ($urandom_range(1500, 1)) step();
            reset = 1'b1;
            repeat ($urandom_range(3, 1)) step();
            reset = 1'b0;
        end
        repeat (50) step();
        @(negedge clk);
        #1;

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/vga_timing_gen.md
Name: vga_timing_gen

Overview:
- Generates 640x480@60 Hz raster timing: the pixel-coordinate, blank and sync stream that the sprite renderers and score-digit drawers consume.
- Produces DrawX/DrawY/blank for the pixel pipelines and drives HS/VS to the connector.
- Delays HS/VS by the renderers' registered-output latency so sync edges line up with the pixel colours.
- Also provides frame/line strobes and a frame counter for game-logic animation.

Parameters:
H_ACTIVE, 640, visible pixels per line
H_FP, 16, horizontal front porch (pixels)
H_SYNC, 96, horizontal sync width
H_BP, 48, horizontal back porch
V_ACTIVE, 480, visible lines per frame
V_FP, 10, vertical front porch (lines)
V_SYNC, 2, vertical sync width
V_BP, 33, vertical back porch
PIPE_DLY, 1, cycles HS/VS are delayed relative to DrawX/DrawY (0..4)
SYNC_POL, 0, asserted level of HS/VS (0 = active-low)

Ports:
vga_clk  in  1  pixel clock (25 MHz nominal); all logic on posedge
reset  in  1  synchronous, active-high reset
DrawX  out  10  current column, 0..H_TOTAL-1
DrawY  out  10  current row, 0..V_TOTAL-1
blank  out  1  1 = visible pixel (DrawX<H_ACTIVE and DrawY<V_ACTIVE), 0 = blanking; aligned with DrawX/DrawY
hs  out  1  horizontal sync, delayed PIPE_DLY cycles
vs  out  1  vertical sync, delayed PIPE_DLY cycles
line_start  out  1  1-cycle pulse when DrawX==0
frame_start  out  1  1-cycle pulse when DrawX==0 and DrawY==0
frame_count  out  16  completed-frame counter, wraps at 65535->0

Behaviour:
- H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP (800); V_TOTAL = V_ACTIVE+V_FP+V_SYNC+V_BP (525).
- DrawX and DrawY are the registered counters themselves, not decoded copies.
- Each cycle DrawX increments. At H_TOTAL-1 it wraps to 0 and DrawY increments. DrawY wraps V_TOTAL-1 -> 0 in the same cycle that DrawX wraps.
- blank, line_start and frame_start are combinational decodes of the current counters. They have zero latency relative to DrawX/DrawY.
- Raw sync asserted for DrawX in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC) = [656,752).
- Raw vsync asserted for DrawY in [V_ACTIVE+V_FP, V_ACTIVE+V_FP+V_SYNC) = [490,492), across entire lines.
- Raw syncs pass through a PIPE_DLY-deep register chain. With PIPE_DLY=0, hs/vs are combinational decodes.
- Output level = SYNC_POL when asserted, ~SYNC_POL otherwise.
- frame_count increments on the clock edge where DrawX==H_TOTAL-1 and DrawY==V_TOTAL-1. It wraps modulo 2^16.
- Reset (synchronous, any point mid-frame) has priority over counting. On the next edge: DrawX=0, DrawY=0, frame_count=0, and every sync delay stage is loaded with the deasserted level.
- Consequences of reset:
  - While reset is held, the counters stay at 0, hs/vs read deasserted, and blank=1.
  - line_start and frame_start are forced to 0.
  - In the first cycle after reset deasserts, frame_start=1 and line_start=1.
- No handshake; the stream is free-running. Consumers sample on posedge vga_clk.

Test Plan:
- Assert reset 3 cycles, release -> cycle 0: DrawX=0, DrawY=0, blank=1, frame_start=1, hs=vs=1 (SYNC_POL=0), frame_count=0.
- Run one line -> DrawX goes 639->640 with blank 1->0. DrawX goes 799->0 with DrawY 0->1 and line_start=1 only at DrawX==0. 800 cycles per line exactly.
- PIPE_DLY=1 -> hs falls the cycle after DrawX==656, rises the cycle after DrawX==752, for 96 low cycles per line. Repeat with PIPE_DLY=0 and PIPE_DLY=3 to confirm shifts of 0 and 3 cycles.
- Run full frame -> vs low for exactly 2x800 cycles starting DrawY==490 (+PIPE_DLY). After 420000 cycles, frame_count=1 and frame_start re-pulses at (0,0).
- Reset asserted at DrawX=700, DrawY=491 (hs and vs both low) -> next edge DrawX=0, DrawY=0, hs=vs=1 immediately, with no residual sync from the delay chain.
- Preload frame_count=65535 via a forced run of 65536 frames (or a force) -> end of frame wraps to 0 with no glitch on the counters.
